card_grid_renderer: RTL

Parametrised pixel source for the memory-game board. It draws a ROWS×COLS grid of CARD_W×CARD_H cards on the 640×480 VGA raster and keeps per-card state (back, face, matched). It runs a frame-paced flip animation through a command handshake and fetches pixels from an external synchronous ROM. Its cardon/rgb outputs feed the top-level colour mux alongside the other sprite layers.

---
 rtl/card_grid_renderer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/card_grid_renderer.sv
// card_grid_renderer: ROWSxCOLS memory-game card grid pixel source with frame-paced flip animation; define CARD_BORDER_EN to draw card borders
module card_grid_renderer #(
  parameter int COLS = 4,
  parameter int ROWS = 4,
  parameter int CARD_W = 100,
  parameter int CARD_H = 100,
  parameter int ORIGIN_X = 121,
  parameter int ORIGIN_Y = 60,
  parameter int RGB_W = 9,
  parameter int FLIP_STEP = 10,
  parameter logic [RGB_W-1:0] MATCH_RGB = 9'h1C0,
  parameter logic [RGB_W-1:0] BORDER_RGB = 9'h1FF,
  localparam int POS_W = $clog2(COLS*ROWS),
  localparam int ADDR_W = $clog2(CARD_W*CARD_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              frame_tick,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [POS_W-1:0]  cmd_pos,
  input  logic [1:0]        cmd_op,
  output logic              cmd_done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [POS_W-1:0]  rom_card,
  output logic              rom_face,
  input  logic [RGB_W-1:0]  rom_data,
  output logic              cardon,
  output logic [RGB_W-1:0]  rgb
);
  localparam int N = COLS*ROWS;
  localparam int HALF = CARD_W/2;
  localparam int XW = $clog2(CARD_W+1);
  localparam logic [1:0] BACK = 2'd0, FACE = 2'd1, MATCHED = 2'd2;
  localparam logic [1:0] IDLE = 2'd0, SHRINK = 2'd1, SWAP = 2'd2, GROW = 2'd3;

  logic [N-1:0][1:0] st;
  logic [1:0]        fsm, tgt, cs;
  logic [XW-1:0]     m;
  logic [POS_W-1:0]  apos, pidx;
  logic              hit, hit_q, hit_q2, mat_q, mat_q2, clip_q, clip_q2, brd_q2;
  int                hx, vy, cx, ry, lx, ly;

  assign cmd_ready = fsm == IDLE;
  assign cs = st[pidx];

  // Hit test and card/local coordinates by comparing against card boundaries (no divider)
  always_comb begin
    hx = int'(hcount) - ORIGIN_X;
    vy = int'(vcount) - ORIGIN_Y;
    hit = hx >= 0 && hx < COLS*CARD_W && vy >= 0 && vy < ROWS*CARD_H;
    cx = 0;
    ry = 0;
    for (int c = 1; c < COLS; c++) cx = hx >= c*CARD_W ? c : cx;
    for (int r = 1; r < ROWS; r++) ry = vy >= r*CARD_H ? r : ry;
    lx = hx - cx*CARD_W;
    ly = vy - ry*CARD_H;
    pidx = POS_W'(ry*COLS + cx);
  end

  // Command handling and flip animation: immediate ops finish in IDLE, flips walk shrink/swap/grow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fsm <= IDLE;
      m <= '0;
      apos <= '0;
      tgt <= BACK;
      cmd_done <= 1'b0;
      st <= {N{BACK}};
    end else begin
      cmd_done <= 1'b0;
      case (fsm)
        IDLE: if (cmd_valid) begin
          apos <= cmd_pos;
          tgt <= cmd_op[0] ? BACK : FACE;
          if (cmd_op[1]) begin
            cmd_done <= 1'b1;
            if (cmd_op[0]) st <= {N{BACK}};
            else st[cmd_pos] <= MATCHED;
          end else if (st[cmd_pos] == MATCHED || st[cmd_pos] == (cmd_op[0] ? BACK : FACE)) begin
            cmd_done <= 1'b1;
          end else begin
            fsm <= SHRINK;
            m <= '0;
          end
        end
        SHRINK: if (frame_tick) begin
          fsm <= int'(m) + FLIP_STEP >= HALF ? SWAP : SHRINK;
          m <= int'(m) + FLIP_STEP >= HALF ? XW'(HALF) : m + XW'(FLIP_STEP);
        end
        SWAP: begin
          st[apos] <= tgt;
          fsm <= GROW;
        end
        default: if (frame_tick) begin
          fsm <= int'(m) <= FLIP_STEP ? IDLE : GROW;
          m <= int'(m) <= FLIP_STEP ? '0 : m - XW'(FLIP_STEP);
          cmd_done <= int'(m) <= FLIP_STEP;
        end
      endcase
    end

  // Stage 1: ROM request plus hit, matched and clip flags for the sampled pixel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rom_addr <= '0;
      rom_card <= '0;
      rom_face <= 1'b0;
      hit_q <= 1'b0;
      mat_q <= 1'b0;
      clip_q <= 1'b0;
    end else begin
      rom_addr <= hit ? ADDR_W'(ly*CARD_W + lx) : '0;
      rom_card <= hit ? pidx : '0;
      rom_face <= hit && cs == FACE;
      hit_q <= hit;
      mat_q <= hit && cs == MATCHED;
      clip_q <= hit && fsm != IDLE && pidx == apos && (lx < int'(m) || lx > CARD_W-1-int'(m));
    end

  // Stage 2: hold flags while the ROM produces its pixel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hit_q2 <= 1'b0;
      mat_q2 <= 1'b0;
      clip_q2 <= 1'b0;
    end else begin
      hit_q2 <= hit_q;
      mat_q2 <= mat_q;
      clip_q2 <= clip_q;
    end

`ifdef CARD_BORDER_EN
  logic brd_q;
  // Border flag rides the same two-stage pipeline; matched cards never get a border
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      brd_q <= 1'b0;
      brd_q2 <= 1'b0;
    end else begin
      brd_q <= hit && cs != MATCHED && (lx == 0 || lx == CARD_W-1 || ly == 0 || ly == CARD_H-1);
      brd_q2 <= brd_q;
    end
`else
  assign brd_q2 = 1'b0;
`endif

  // Stage 3: final colour select; blank outside the grid and in clipped columns
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cardon <= 1'b0;
      rgb <= '0;
    end else begin
      cardon <= hit_q2 && !clip_q2;
      rgb <= (!hit_q2 || clip_q2) ? '0 : mat_q2 ? MATCH_RGB : brd_q2 ? BORDER_RGB : rom_data;
    end
endmodule
